// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and helpers for the VGA image pipeline
// Contents:
//   filter_mode_e : colour filter selection (pass / gray / invert / threshold)
//   rgb444_t      : packed 4-bit-per-channel pixel
//   pix_ctrl_t    : per-pixel control bits carried down the ROM-latency delay line
//   gray4()       : 4-bit luma from 4-bit r/g/b, (77r+150g+29b)>>8
package vga_pkg;

    typedef enum logic [1:0] {
        FM_PASS   = 2'd0,
        FM_GRAY   = 2'd1,
        FM_INVERT = 2'd2,
        FM_THRESH = 2'd3
    } filter_mode_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic de;
        logic in_img;
        logic h_sync;
        logic v_sync;
    } pix_ctrl_t;

    localparam rgb444_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb444_t RGB_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};

    // Worst case 15*(77+150+29) = 3840, so 12 bits never overflow.
    function automatic logic [3:0] gray4(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        logic [11:0] acc;
        acc = 12'd77 * {8'd0, r} + 12'd150 * {8'd0, g} + 12'd29 * {8'd0, b};
        return acc[11:8];
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel-tick divider, h/v counters, sync/DE/frame_start generation
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   tick                : one-clk pixel tick, every PIX_DIV clks (first one PIX_DIV clks after reset)
//   h_cnt, v_cnt        : current pixel position, advance on tick
//   h_sync, v_sync      : undelayed active-low syncs for the current position
//   de                  : current position is in the active area
//   frame_start         : tick at h=0, v=0
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 4,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    output logic          tick,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_sync,
    output logic          v_sync,
    output logic          de,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_q;
    logic          tick_q;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;

    // The tick is registered so it is low throughout reset and first rises
    // exactly PIX_DIV clks after release, even when PIX_DIV is 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
        end else begin
            if (div_q == DIV_LAST) begin
                div_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                div_q  <= div_q + 1'b1;
                tick_q <= 1'b0;
            end
            if (tick_q) begin
                if (h_q == H_LAST) begin
                    h_q <= '0;
                    v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
                end else begin
                    h_q <= h_q + 1'b1;
                end
            end
        end
    end

    assign tick        = tick_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign h_sync      = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign v_sync      = !((v_q >= VS_BEG) && (v_q < VS_END));
    assign de          = (h_q < H_ACT) && (v_q < V_ACT);
    assign frame_start = tick_q && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_img_pipeline.sv
// rtl/vga_img_pipeline.sv - VGA timing, upscaled image-ROM addressing, latency-aligned sync/DE and colour filter
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   mode[1:0]           : filter select, latched on frame_start (0 pass, 1 gray, 2 invert, 3 threshold)
//   rom_addr            : registered image ROM address, held while outside the image
//   rom_data[15:0]      : RGB565 pixel, valid ROM_LAT pixel ticks after rom_addr
//   r_port/g_port/b_port: 4-bit colour outputs
//   h_sync, v_sync      : active-low syncs, delayed to line up with colour
//   frame_start         : undelayed one-clk pulse on the tick at h=0, v=0
// Build option: VGA_BORDER_EN draws a 1-pixel white frame on the outermost in-image pixels.
module vga_img_pipeline
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int PIX_DIV     = 4,
    parameter int ROM_LAT     = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [1:0]                         mode,
    output logic [$clog2(IMG_W*IMG_H)-1:0]     rom_addr,
    input  logic [15:0]                        rom_data,
    output logic [3:0]                         r_port,
    output logic [3:0]                         g_port,
    output logic [3:0]                         b_port,
    output logic                               h_sync,
    output logic                               v_sync,
    output logic                               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(IMG_W * IMG_H);
    // address register + ROM latency + filter register
    localparam int DLY     = ROM_LAT + 2;

    // Displayed image extent after upscaling, clipped to the active area.
    localparam int IMG_COLS = ((IMG_W << SCALE_SHIFT) < H_ACTIVE) ? (IMG_W << SCALE_SHIFT) : H_ACTIVE;
    localparam int IMG_ROWS = ((IMG_H << SCALE_SHIFT) < V_ACTIVE) ? (IMG_H << SCALE_SHIFT) : V_ACTIVE;
    localparam logic [HW-1:0] IMG_X_END = HW'(IMG_COLS);
    localparam logic [VW-1:0] IMG_Y_END = VW'(IMG_ROWS);

    logic          tick;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          tg_h_sync;
    logic          tg_v_sync;
    logic          tg_de;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .PIX_DIV  (PIX_DIV),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_sync      (tg_h_sync),
        .v_sync      (tg_v_sync),
        .de          (tg_de),
        .frame_start (frame_start)
    );

    // ---------------------------------------------------------------- addressing
    logic          in_img;
    logic [AW-1:0] x_img;
    logic [AW-1:0] y_img;
    logic [AW-1:0] addr_next;
    logic [AW-1:0] rom_addr_q;

    assign in_img    = tg_de && (h_cnt < IMG_X_END) && (v_cnt < IMG_Y_END);
    assign x_img     = AW'(h_cnt >> SCALE_SHIFT);
    assign y_img     = AW'(v_cnt >> SCALE_SHIFT);
    assign addr_next = AW'(y_img * AW'(IMG_W)) + x_img;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr_q <= '0;
        end else if (tick && in_img) begin
            rom_addr_q <= addr_next;
        end
    end

    assign rom_addr = rom_addr_q;

    // ---------------------------------------------------------------- delay line
    pix_ctrl_t ctrl_in;
    pix_ctrl_t dly_q [DLY];

    assign ctrl_in = '{de: tg_de, in_img: in_img, h_sync: tg_h_sync, v_sync: tg_v_sync};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DLY; i++) begin
                dly_q[i] <= '{de: 1'b0, in_img: 1'b0, h_sync: 1'b1, v_sync: 1'b1};
            end
        end else if (tick) begin
            dly_q[0] <= ctrl_in;
            for (int i = 1; i < DLY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

`ifdef VGA_BORDER_EN
    // Border flag rides alongside the control bits up to the filter stage.
    logic           border_in;
    logic [DLY-2:0] brd_q;

    assign border_in = in_img && ((h_cnt == '0) || (h_cnt == IMG_X_END - 1'b1) ||
                                  (v_cnt == '0) || (v_cnt == IMG_Y_END - 1'b1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brd_q <= '0;
        end else if (tick) begin
            brd_q <= {brd_q[DLY-3:0], border_in};
        end
    end
`endif

    // ---------------------------------------------------------------- filter
    filter_mode_e active_mode_q;

    // Sampled only at frame start so a frame is never filtered two ways.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_mode_q <= FM_PASS;
        end else if (frame_start) begin
            active_mode_q <= filter_mode_e'(mode);
        end
    end

    logic [3:0] r4;
    logic [3:0] g4;
    logic [3:0] b4;
    logic [3:0] y4;
    logic       unused_rom_bits;
    rgb444_t    filt_pix;
    rgb444_t    rgb_q;

    assign r4 = rom_data[15:12];
    assign g4 = rom_data[10:7];
    assign b4 = rom_data[4:1];
    assign y4 = gray4(r4, g4, b4);
    assign unused_rom_bits = ^{rom_data[11], rom_data[6:5], rom_data[0]};

    // dly_q[DLY-2] holds the flags of the pixel whose ROM word is on rom_data now.
    always_comb begin
        filt_pix = RGB_BLACK;
        case (active_mode_q)
            FM_PASS:   filt_pix = '{r: r4, g: g4, b: b4};
            FM_GRAY:   filt_pix = '{r: y4, g: y4, b: y4};
            FM_INVERT: filt_pix = '{r: ~r4, g: ~g4, b: ~b4};
            FM_THRESH: filt_pix = (y4 >= 4'd8) ? RGB_WHITE : RGB_BLACK;
            default:   filt_pix = RGB_BLACK;
        endcase
        if (!(dly_q[DLY-2].de && dly_q[DLY-2].in_img)) begin
            filt_pix = RGB_BLACK;
        end
`ifdef VGA_BORDER_EN
        else if (brd_q[DLY-2]) begin
            filt_pix = RGB_WHITE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q <= RGB_BLACK;
        end else if (tick) begin
            rgb_q <= filt_pix;
        end
    end

    assign r_port = rgb_q.r;
    assign g_port = rgb_q.g;
    assign b_port = rgb_q.b;
    assign h_sync = dly_q[DLY-1].h_sync;
    assign v_sync = dly_q[DLY-1].v_sync;

endmodule

// File: tb/tb_vga_img_pipeline.sv
// tb/tb_vga_img_pipeline.sv - scoreboard bench for vga_img_pipeline on a reduced raster
module tb_vga_img_pipeline;

    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACTIVE = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int IMG_W = 6, IMG_H = 5, SCALE_SHIFT = 1;
    localparam int PIX_DIV = 2, ROM_LAT = 2;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int AW = $clog2(IMG_W * IMG_H);
    localparam int DLY = ROM_LAT + 2;
    localparam int WAIT_MAX = 4000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [3:0]    r_port, g_port, b_port;
    logic          h_sync, v_sync, frame_start;

    always #5 clk = ~clk;

    vga_img_pipeline #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SHIFT(SCALE_SHIFT),
        .PIX_DIV(PIX_DIV), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .r_port(r_port), .g_port(g_port), .b_port(b_port),
        .h_sync(h_sync), .v_sync(v_sync), .frame_start(frame_start)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Environment pixel clock: tick every PIX_DIV clks, first one PIX_DIV clks after reset release.
    int   tdiv;
    logic tb_tick;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tdiv    <= 0;
            tb_tick <= 1'b0;
        end else if (tdiv == PIX_DIV - 1) begin
            tdiv    <= 0;
            tb_tick <= 1'b1;
        end else begin
            tdiv    <= tdiv + 1;
            tb_tick <= 1'b0;
        end
    end

    // Image ROM with ROM_LAT pixel-tick latency.
    logic [15:0] rom_mem  [32];
    logic [15:0] rom_pipe [ROM_LAT];
    assign rom_data = rom_pipe[ROM_LAT-1];
    always @(posedge clk) begin
        if (tb_tick) begin
            rom_pipe[0] <= rom_mem[rom_addr];
            for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
        end
    end

    function automatic logic [11:0] model_rgb(input int m, input logic [15:0] d);
        int r, g, b, y;
        r = int'(d[15:12]);
        g = int'(d[10:7]);
        b = int'(d[4:1]);
        y = (77 * r + 150 * g + 29 * b) / 256;
        case (m)
            0:       return {d[15:12], d[10:7], d[4:1]};
            1:       return {y[3:0], y[3:0], y[3:0]};
            2:       return {~d[15:12], ~d[10:7], ~d[4:1]};
            default: return (y >= 8) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    // Scoreboard: expected {h_sync, v_sync, rgb} pushed per pixel tick, popped DLY ticks later.
    int            mh, mv, m_mode, m_addr_i;
    logic [AW-1:0] m_addr;
    logic [13:0]   sb [$];
    logic [13:0]   exp_e;
    logic          m_de, m_in, m_hs, m_vs;
    logic [11:0]   m_rgb;

    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            for (int i = 0; i < DLY; i++) sb.push_back({1'b1, 1'b1, 12'h000});
            mh = 0; mv = 0; m_mode = 0; m_addr = '0;
        end else begin
            check("frame_start", 32'(frame_start), 32'(tb_tick && mh == 0 && mv == 0));
            if (tb_tick) begin
                check("rom_addr", 32'(rom_addr), 32'(m_addr));
                if (mh == 0 && mv == 0) m_mode = int'(mode);
                m_de = (mh < H_ACTIVE) && (mv < V_ACTIVE);
                m_in = m_de && ((mh >> SCALE_SHIFT) < IMG_W) && ((mv >> SCALE_SHIFT) < IMG_H);
                m_hs = !((mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC));
                m_vs = !((mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC));
                m_addr_i = (mv >> SCALE_SHIFT) * IMG_W + (mh >> SCALE_SHIFT);
                m_rgb = 12'h000;
                if (m_in) m_rgb = model_rgb(m_mode, rom_mem[m_addr_i]);
                sb.push_back({m_hs, m_vs, m_rgb});
                exp_e = sb.pop_front();
                check("pixel", 32'({h_sync, v_sync, r_port, g_port, b_port}), 32'(exp_e));
                if (m_in) m_addr = AW'(m_addr_i);
                if (mh == H_TOTAL - 1) begin
                    mh = 0;
                    mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
        end
    end

    // Returns at posedge+1 of the tick cycle that presents pixel (h, v).
    task automatic wait_pixel(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(tb_tick && mh == h && mv == v) && n < WAIT_MAX);
        if (n >= WAIT_MAX) check("wait_pixel_timeout", 32'(n), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hsync"}, 32'(h_sync), 32'd1);
        check({tag, "_vsync"}, 32'(v_sync), 32'd1);
        check({tag, "_rgb"}, 32'({r_port, g_port, b_port}), 32'd0);
        check({tag, "_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    task automatic release_and_time_fs(input string tag);
        int n;
        reset = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_start && n < 50);
        check(tag, 32'(n), 32'(PIX_DIV));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = 16'($urandom);
        rom_mem[0] = 16'hF800;
        rom_mem[1] = 16'h0000;
        rom_mem[2] = 16'hFFFF;
        for (int i = 0; i < ROM_LAT; i++) rom_pipe[i] = 16'h0000;

        reset = 1'b0;
        mode  = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        release_and_time_fs("first_fs_clks");

        // Frame 0 stays pass although mode changes mid-frame.
        wait_pixel(0, 4);
        mode = 2'd2;
        // Frame 1 inverted; switch to gray mid-frame.
        wait_pixel(0, 0);
        wait_pixel(5, 6);
        mode = 2'd1;
        // Frame 2 gray; switch to pass mid-frame.
        wait_pixel(0, 0);
        wait_pixel(3, 3);
        mode = 2'd0;
        // Change on the frame_start tick itself: frame 3 thresholded.
        wait_pixel(0, 0);
        mode = 2'd3;

        // Reset in the middle of the image.
        wait_pixel(10, 6);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        release_and_time_fs("rerelease_fs_clks");

        wait_pixel(0, 0);
        wait_pixel(0, V_ACTIVE + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
